// File: rtl/uart_icb_bridge.sv
// UART-to-ICB bridge: 8N1 command frames in, single-word bus access, response bytes out.
// Write frame: A5 ADDR_H ADDR_L D3 D2 D1 D0 -> reply 06. Read frame: 5A ADDR_H ADDR_L -> 4 bytes.
module uart_icb_bridge #(
  parameter int unsigned CLK_DIV  = 434,
  parameter int unsigned GAP_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxpin,
  output logic        uart_txpin,
  output logic        icb_wr,
  output logic [9:0]  icb_wadr,
  output logic [31:0] icb_wdat,
  input  logic        icb_wack,
  output logic        icb_rd,
  output logic [9:0]  icb_radr,
  input  logic [31:0] icb_rdat,
  input  logic        icb_rack,
  output logic        busy,
  output logic        err
);

  localparam logic [15:0] DivLast  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HalfLast = 16'(CLK_DIV / 2 - 1);
  localparam logic [31:0] GapLast  = 32'(GAP_BITS * CLK_DIV - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {StCmd, StAddrH, StAddrL, StData, StBus, StResp} state_e;

  // ---------------------------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------------------------
  logic        rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e   rx_state_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_bit_q;
  logic [7:0]  rx_shift_q;
  logic        rx_valid_q;
  logic        rx_ferr_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= uart_rxpin;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX bit sampler: validate start at half period, then sample every full period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      unique case (rx_state_q)
        RxIdle: begin
          if (rx_prev_q && !rx_s2_q) begin
            rx_state_q <= RxStart;
            rx_cnt_q   <= '0;
          end
        end
        RxStart: begin
          if (rx_cnt_q == HalfLast) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            // A high line here was a glitch, not a start bit.
            rx_state_q <= rx_s2_q ? RxIdle : RxData;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxData: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RxStop;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        RxStop: begin
          if (rx_cnt_q == DivLast) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RxIdle;
            if (rx_s2_q) rx_valid_q <= 1'b1;
            else         rx_ferr_q  <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 16'd1;
          end
        end
        default: rx_state_q <= RxIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Frame parser, bus master and transmitter
  // ---------------------------------------------------------------------------------------------
  state_e      state_q;
  logic        is_wr_q;
  logic [1:0]  addr_hi_q;
  logic [1:0]  dcnt_q;
  logic [31:0] gap_q;
  logic        req_sent_q;
  logic [31:0] resp_q;
  logic [2:0]  resp_left_q;
  logic        tx_on_q;
  logic [8:0]  tx_shift_q;
  logic [3:0]  tx_bit_q;
  logic [15:0] tx_cnt_q;

  assign busy = (state_q != StCmd);

  // Main FSM: collects the frame, runs one bus access, then serialises the reply.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StCmd;
      is_wr_q     <= 1'b0;
      addr_hi_q   <= '0;
      dcnt_q      <= '0;
      gap_q       <= '0;
      req_sent_q  <= 1'b0;
      resp_q      <= '0;
      resp_left_q <= '0;
      tx_on_q     <= 1'b0;
      tx_shift_q  <= '1;
      tx_bit_q    <= '0;
      tx_cnt_q    <= '0;
      uart_txpin  <= 1'b1;
      icb_wr      <= 1'b0;
      icb_rd      <= 1'b0;
      icb_wadr    <= '0;
      icb_radr    <= '0;
      icb_wdat    <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state_q)
        StCmd: begin
          if (rx_ferr_q) begin
            err <= 1'b1;
          end else if (rx_valid_q) begin
            gap_q <= '0;
            if (rx_shift_q == 8'hA5) begin
              is_wr_q <= 1'b1;
              state_q <= StAddrH;
            end else if (rx_shift_q == 8'h5A) begin
              is_wr_q <= 1'b0;
              state_q <= StAddrH;
            end
          end
        end
        StAddrH, StAddrL, StData: begin
          if (rx_ferr_q) begin
            err     <= 1'b1;
            state_q <= StCmd;
          end else if (rx_valid_q) begin
            gap_q <= '0;
            if (state_q == StAddrH) begin
              addr_hi_q <= rx_shift_q[1:0];
              state_q   <= StAddrL;
            end else if (state_q == StAddrL) begin
              req_sent_q <= 1'b0;
              dcnt_q     <= '0;
              if (is_wr_q) begin
                icb_wadr <= {addr_hi_q, rx_shift_q};
                state_q  <= StData;
              end else begin
                icb_radr <= {addr_hi_q, rx_shift_q};
                state_q  <= StBus;
              end
            end else begin
              icb_wdat <= {icb_wdat[23:0], rx_shift_q};
              dcnt_q   <= dcnt_q + 2'd1;
              if (dcnt_q == 2'd3) state_q <= StBus;
            end
          end else if (gap_q == GapLast) begin
            err     <= 1'b1;
            state_q <= StCmd;
          end else begin
            gap_q <= gap_q + 32'd1;
          end
        end
        StBus: begin
          if (rx_valid_q || rx_ferr_q) err <= 1'b1;
          if (!req_sent_q) begin
            req_sent_q <= 1'b1;
            icb_wr     <= is_wr_q;
            icb_rd     <= !is_wr_q;
          end else if ((icb_wr && icb_wack) || (icb_rd && icb_rack)) begin
            icb_wr      <= 1'b0;
            icb_rd      <= 1'b0;
            resp_q      <= is_wr_q ? 32'h0600_0000 : icb_rdat;
            resp_left_q <= is_wr_q ? 3'd1 : 3'd4;
            tx_on_q     <= 1'b0;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rx_valid_q || rx_ferr_q) err <= 1'b1;
          if (!tx_on_q) begin
            tx_on_q    <= 1'b1;
            uart_txpin <= 1'b0;
            tx_shift_q <= {1'b1, resp_q[31:24]};
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
          end else if (tx_cnt_q != DivLast) begin
            tx_cnt_q <= tx_cnt_q + 16'd1;
          end else begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              if (resp_left_q == 3'd1) begin
                tx_on_q    <= 1'b0;
                uart_txpin <= 1'b1;
                state_q    <= StCmd;
              end else begin
                // Next byte starts right after the stop bit, no idle gap.
                resp_left_q <= resp_left_q - 3'd1;
                resp_q      <= {resp_q[23:0], 8'h00};
                uart_txpin  <= 1'b0;
                tx_shift_q  <= {1'b1, resp_q[23:16]};
                tx_bit_q    <= '0;
              end
            end else begin
              uart_txpin <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
              tx_bit_q   <= tx_bit_q + 4'd1;
            end
          end
        end
        default: state_q <= StCmd;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_icb_bridge.sv
// Directed bench for uart_icb_bridge: vector table of frames plus corner-case sequences.
module tb_uart_icb_bridge;

  localparam int CLK_DIV  = 16;
  localparam int GAP_BITS = 20;

  logic        clk;
  logic        rst;
  logic        uart_rxpin;
  logic        uart_txpin;
  logic        icb_wr;
  logic [9:0]  icb_wadr;
  logic [31:0] icb_wdat;
  logic        icb_wack;
  logic        icb_rd;
  logic [9:0]  icb_radr;
  logic [31:0] icb_rdat;
  logic        icb_rack;
  logic        busy;
  logic        err;

  uart_icb_bridge #(
    .CLK_DIV  (CLK_DIV),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxpin (uart_rxpin),
    .uart_txpin (uart_txpin),
    .icb_wr     (icb_wr),
    .icb_wadr   (icb_wadr),
    .icb_wdat   (icb_wdat),
    .icb_wack   (icb_wack),
    .icb_rd     (icb_rd),
    .icb_radr   (icb_radr),
    .icb_rdat   (icb_rdat),
    .icb_rack   (icb_rack),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: ack after ack_delay cycles of request.
  int ack_delay;
  int wcnt, rcnt;
  always @(posedge clk) begin
    wcnt <= icb_wr ? wcnt + 1 : 0;
    rcnt <= icb_rd ? rcnt + 1 : 0;
  end
  assign icb_wack = icb_wr && (wcnt == ack_delay);
  assign icb_rack = icb_rd && (rcnt == ack_delay);

  // Monitors: accumulate totals only; the test takes deltas.
  int         wr_total, rd_total, err_total, busy_total, overlap_total, unstable_total;
  int         tx_low_total;
  logic       prev_wr, prev_rd;
  logic [9:0] prev_wadr, prev_radr, last_wadr, last_radr;
  logic [31:0] prev_wdat, last_wdat;
  initial begin
    wr_total = 0; rd_total = 0; err_total = 0; busy_total = 0;
    overlap_total = 0; unstable_total = 0; tx_low_total = 0;
    wcnt = 0; rcnt = 0;
  end

  always @(negedge clk) begin
    if (icb_wr) begin
      wr_total  <= wr_total + 1;
      last_wadr <= icb_wadr;
      last_wdat <= icb_wdat;
    end
    if (icb_rd) begin
      rd_total  <= rd_total + 1;
      last_radr <= icb_radr;
    end
    if (icb_wr && icb_rd) overlap_total <= overlap_total + 1;
    if ((icb_wr && prev_wr && (icb_wadr != prev_wadr || icb_wdat != prev_wdat)) ||
        (icb_rd && prev_rd && icb_radr != prev_radr))
      unstable_total <= unstable_total + 1;
    if (err) err_total <= err_total + 1;
    if (busy) busy_total <= busy_total + 1;
    if (!uart_txpin) tx_low_total <= tx_low_total + 1;
    prev_wr   <= icb_wr;
    prev_rd   <= icb_rd;
    prev_wadr <= icb_wadr;
    prev_radr <= icb_radr;
    prev_wdat <= icb_wdat;
  end

  // Serial decoder for uart_txpin, sampling mid-bit.
  logic [7:0] byte_log[$];
  int         stop_err_total;
  int         dec_cnt;
  logic       dec_on;
  logic       tx_prev;
  logic [7:0] dec_byte;
  initial begin
    stop_err_total = 0; dec_on = 1'b0; dec_cnt = 0; tx_prev = 1'b1; dec_byte = '0;
  end
  always @(posedge clk) begin
    tx_prev <= uart_txpin;
    if (!rst) begin
      dec_on <= 1'b0;
    end else if (!dec_on) begin
      if (tx_prev && !uart_txpin) begin
        dec_on  <= 1'b1;
        dec_cnt <= 2;
      end
    end else begin
      dec_cnt <= dec_cnt + 1;
      if ((dec_cnt % CLK_DIV) == CLK_DIV / 2 && dec_cnt > CLK_DIV) begin
        if (dec_cnt / CLK_DIV <= 8) begin
          dec_byte[(dec_cnt / CLK_DIV) - 1] <= uart_txpin;
        end else begin
          if (!uart_txpin) stop_err_total <= stop_err_total + 1;
          byte_log.push_back(dec_byte);
          dec_on <= 1'b0;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rxpin = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_rxpin = b[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    uart_rxpin = stop;
    repeat (CLK_DIV) @(posedge clk);
    #1;
    uart_rxpin = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int c = 0; c < 20000 && !done; c++) begin
      @(posedge clk);
      #1;
      if (!busy) done = 1;
    end
    if (!done) check({name, "_idle_timeout"}, 32'd1, 32'd0);
  endtask

  typedef struct {
    logic [55:0] rx;
    int          n_rx;
    logic [31:0] rdat;
    int          delay;
    int          exp_wr;
    int          exp_rd;
    logic [9:0]  exp_adr;
    logic [31:0] exp_wdat;
    logic [31:0] resp;
    int          n_resp;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs[NV];

  task automatic run_vec(input int v);
    int w0, r0, e0, b0, n0;
    logic [55:0] rx;
    logic [31:0] resp;
    string tag;
    tag = $sformatf("v%0d", v);
    w0 = wr_total; r0 = rd_total; e0 = err_total; b0 = busy_total; n0 = byte_log.size();
    ack_delay = vecs[v].delay;
    icb_rdat  = vecs[v].rdat;
    rx = vecs[v].rx;
    for (int i = 0; i < vecs[v].n_rx; i++) send_byte(rx[55 - 8 * i -: 8], 1'b1);
    wait_idle(tag);
    repeat (2 * CLK_DIV) @(posedge clk);
    #1;
    check({tag, "_wr_cycles"}, wr_total - w0, vecs[v].exp_wr);
    check({tag, "_rd_cycles"}, rd_total - r0, vecs[v].exp_rd);
    if (vecs[v].exp_wr > 0) begin
      check({tag, "_wadr"}, {22'd0, last_wadr}, {22'd0, vecs[v].exp_adr});
      check({tag, "_wdat"}, last_wdat, vecs[v].exp_wdat);
    end
    if (vecs[v].exp_rd > 0) check({tag, "_radr"}, {22'd0, last_radr}, {22'd0, vecs[v].exp_adr});
    check({tag, "_resp_count"}, byte_log.size() - n0, vecs[v].n_resp);
    resp = vecs[v].resp;
    for (int i = 0; i < vecs[v].n_resp && n0 + i < byte_log.size(); i++)
      check($sformatf("%s_resp%0d", tag, i), {24'd0, byte_log[n0 + i]}, {24'd0, resp[31 - 8 * i -: 8]});
    check({tag, "_err"}, err_total - e0, 0);
    if (vecs[v].n_resp == 0) check({tag, "_busy_stays_low"}, busy_total - b0, 0);
    check({tag, "_busy_low_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int w0, r0, e0, n0, tl0;
    bit got;
    vecs[0] = '{56'hA5000C00000055, 7, 32'h0, 0, 1, 0, 10'h00C, 32'h00000055, 32'h06000000, 1};
    vecs[1] = '{56'h5A000400000000, 3, 32'h00000001, 0, 0, 1, 10'h004, 32'h0, 32'h00000001, 4};
    vecs[2] = '{56'h5AFF1000000000, 3, 32'hDEADBEEF, 3, 0, 4, 10'h310, 32'h0, 32'hDEADBEEF, 4};
    vecs[3] = '{56'h33000000000000, 1, 32'h0, 0, 0, 0, 10'h000, 32'h0, 32'h0, 0};
    vecs[4] = '{56'hA513FF12345678, 7, 32'h0, 2, 3, 0, 10'h3FF, 32'h12345678, 32'h06000000, 1};

    rst = 1'b0; uart_rxpin = 1'b1; icb_rdat = '0; ack_delay = 0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_txpin", {31'd0, uart_txpin}, 32'd1);
    check("rst_wr", {31'd0, icb_wr}, 32'd0);
    check("rst_rd", {31'd0, icb_rd}, 32'd0);
    check("rst_wadr", {22'd0, icb_wadr}, 32'd0);
    check("rst_radr", {22'd0, icb_radr}, 32'd0);
    check("rst_wdat", icb_wdat, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    for (int v = 0; v < NV; v++) run_vec(v);

    // Gap timeout: partial write frame then silence.
    w0 = wr_total; e0 = err_total;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat ((GAP_BITS + 1) * CLK_DIV) @(posedge clk);
    #1;
    check("gap_err", err_total - e0, 1);
    check("gap_no_wr", wr_total - w0, 0);
    check("gap_busy", {31'd0, busy}, 32'd0);
    run_vec(1);

    // Framing error: stop bit low.
    e0 = err_total;
    send_byte(8'hA5, 1'b0);
    repeat (2 * CLK_DIV) @(posedge clk);
    #1;
    check("ferr_err", err_total - e0, 1);
    check("ferr_busy", {31'd0, busy}, 32'd0);
    run_vec(0);

    // Reset during the second read-response byte.
    ack_delay = 0;
    icb_rdat  = 32'h11223344;
    n0 = byte_log.size();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h04, 1'b1);
    got = 0;
    for (int c = 0; c < 5000 && !got; c++) begin
      @(posedge clk);
      #1;
      if (byte_log.size() > n0) got = 1;
    end
    check("rstmid_first_byte_seen", {31'd0, got}, 32'd1);
    if (got) check("rstmid_first_byte", {24'd0, byte_log[n0]}, 32'h11);
    repeat (3 * CLK_DIV) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rstmid_txpin", {31'd0, uart_txpin}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    w0 = wr_total; r0 = rd_total; tl0 = tx_low_total; n0 = byte_log.size();
    repeat (60 * CLK_DIV) @(posedge clk);
    #1;
    check("rstmid_no_tx", tx_low_total - tl0, 0);
    check("rstmid_no_bytes", byte_log.size() - n0, 0);
    check("rstmid_no_bus", (wr_total - w0) + (rd_total - r0), 0);

    check("wr_rd_overlap", overlap_total, 0);
    check("bus_hold_stable", unstable_total, 0);
    check("tx_stop_bits", stop_err_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_icb_bridge.md
UART_ICB_BRIDGE -- requirements
Module: uart_icb_bridge

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, giving the UART bit period in clk cycles (50 MHz, 115200 bps).
REQ-002 SHALL have parameter GAP_BITS, default 20, giving the inter-byte timeout in bit periods.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port uart_rxpin, input, 1 bit: serial command input, asynchronous.
REQ-006 SHALL have port uart_txpin, output, 1 bit: serial response output.
REQ-007 SHALL have port icb_wr, output, 1 bit: write request.
REQ-008 SHALL have port icb_wadr, output, 10 bits: write address.
REQ-009 SHALL have port icb_wdat, output, 32 bits: write data.
REQ-010 SHALL have port icb_wack, input, 1 bit: write acknowledge.
REQ-011 SHALL have port icb_rd, output, 1 bit: read request.
REQ-012 SHALL have port icb_radr, output, 10 bits: read address.
REQ-013 SHALL have port icb_rdat, input, 32 bits: read data.
REQ-014 SHALL have port icb_rack, input, 1 bit: read acknowledge.
REQ-015 SHALL have port busy, output, 1 bit: high while a frame is in progress (any parser state other than S_CMD).
REQ-016 SHALL have port err, output, 1 bit: one-cycle error pulse.

Function
REQ-017 Serial format SHALL be 8N1, LSB first, with idle line high.
REQ-018 uart_rxpin SHALL pass through a 2-flop synchronizer before any use.
REQ-019 RX start detection: a synchronized falling edge SHALL start a receive; the line SHALL be re-sampled at CLK_DIV/2 (integer division).
REQ-020 RX start validation: if the line is high at the CLK_DIV/2 sample, the start is false and the receiver SHALL silently return to idle.
REQ-021 RX data sampling: data bits and the stop bit SHALL each be sampled every CLK_DIV cycles after the start-bit midpoint.
REQ-022 RX byte completion: a valid byte SHALL produce a one-cycle internal rx_valid pulse at the stop-bit sample.
REQ-023 RX framing error: a stop bit sampled at 0 SHALL cause the byte to be discarded, err to pulse, and the parser to return to S_CMD.
REQ-024 Command bytes: 0xA5 SHALL mean write; 0x5A SHALL mean read.
REQ-025 Any other byte received in S_CMD SHALL be discarded with no response and no err pulse.
REQ-026 Frame layout: command, ADDR_H, ADDR_L, then for writes only DATA[31:24], [23:16], [15:8], [7:0].
REQ-027 Address formation: address = {ADDR_H[1:0], ADDR_L}; ADDR_H[7:2] SHALL be ignored.
REQ-028 Parser states SHALL be S_CMD, S_ADDR_H, S_ADDR_L, S_DATA (2-bit byte counter 0..3), S_BUS, S_RESP.
REQ-029 Transitions: S_CMD -> S_ADDR_H -> S_ADDR_L; S_ADDR_L -> S_DATA for a write, S_ADDR_L -> S_BUS for a read; S_DATA -> S_BUS after the 4th byte; S_BUS -> S_RESP on ack; S_RESP -> S_CMD when the final TX stop bit ends.
REQ-030 Gap timeout: in S_ADDR_H, S_ADDR_L and S_DATA, a gap counter SHALL reset on each rx_valid.
REQ-031 Gap timeout expiry: reaching GAP_BITS*CLK_DIV cycles SHALL return the parser to S_CMD and pulse err; the partial frame SHALL be dropped with no bus access.
REQ-032 Bus request: icb_wr or icb_rd SHALL assert on the first cycle after entering S_BUS.
REQ-033 Bus hold: address and data outputs SHALL stay stable while the request is high.
REQ-034 Bus release: the request SHALL deassert the cycle after icb_wack or icb_rack is sampled high; with a same-cycle-acking responder, the request is exactly 1 cycle wide.
REQ-035 Read data capture: icb_rdat SHALL be captured on the cycle icb_rack is sampled high.
REQ-036 icb_wr and icb_rd SHALL never be high together; there SHALL be no bus timeout.
REQ-037 Response: a write SHALL return one byte, 0x06; a read SHALL return 4 bytes, MSB first.
REQ-038 TX byte-to-byte timing: transmission SHALL start the cycle after entering S_RESP, with back-to-back bytes and no idle gap.
REQ-039 TX bit timing: each TX bit SHALL last exactly CLK_DIV cycles.
REQ-040 rx_valid occurring in S_BUS or S_RESP SHALL cause the byte to be discarded and err to pulse; the current frame SHALL continue unaffected.

Reset
REQ-041 While rst=0, the design SHALL drive uart_txpin=1, icb_wr=0, icb_rd=0, icb_wadr=0, icb_radr=0, icb_wdat=0, busy=0, err=0.
REQ-042 During reset, the parser SHALL be held in S_CMD with all counters at 0 and both RX and TX idle.
REQ-043 Reset asserted mid-frame or mid-TX SHALL abort the operation; uart_txpin SHALL be 1 on the first cycle after the reset edge, and no bus request SHALL be issued afterwards.

Verification
REQ-044 Write: RX A5 00 0C 00 00 00 55, responder acks same cycle -> exactly one icb_wr cycle with wadr=0x00C, wdat=0x00000055; TX 0x06; busy low after the stop bit.
REQ-045 Read: RX 5A 00 04, responder returns rdat=0x00000001 with rack same cycle -> one icb_rd cycle with radr=0x004; TX 00 00 00 01.
REQ-046 Address masking and delayed ack: RX 5A FF 10, rack delayed 3 cycles -> radr=0x310, icb_rd high for 4 cycles.
REQ-047 Bad command: RX 0x33 -> no bus request, no TX activity, err stays low, busy stays low.
REQ-048 Gap timeout and framing error: (a) RX A5 00 then silence for 21 bit times -> err pulse, no icb_wr, and a following valid read succeeds; (b) a byte with stop bit 0 -> err pulse, parser back in S_CMD.
REQ-049 Reset mid-response: rst=0 during the 2nd read-response byte -> uart_txpin=1 next cycle; no further TX after release.
